// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX result, completes loads against a
// variable-latency data memory, and drives WB, ID forwarding and HI/LO forwarding.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 77,
    parameter int MEM_TO_WB_WD = 70,
    parameter int HILO_WD      = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [HILO_WD-1:0]      ex_to_mem1,
    input  logic [31:0]             data_rdata,
    input  logic                    data_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [HILO_WD-1:0]      mem_to_wb1,
    output logic [37:0]             mem_to_id_bus,
    output logic [HILO_WD-1:0]      mem_to_id_2,
    output logic                    stallreq_mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic [HILO_WD-1:0]      hilo_r;
    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [31:0]             rdata_buf;
    logic [31:0]             rdata_buf_nxt;

    logic [31:0] pc;
    logic [4:0]  load_op;
    logic [1:0]  addr_lo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        is_load;
    logic        bus_update;
    logic        bubble;

    logic [31:0] raw;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    logic unused_stall;

    assign unused_stall = ^{stall[5], stall[2:0]};

    // The register changes whenever MEM advances or a bubble is pushed into it.
    assign bubble     = stall[3] & ~stall[4];
    assign bus_update = ~stall[3] | bubble;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_r  <= '0;
            hilo_r <= '0;
        end else if (bubble) begin
            bus_r  <= '0;
            hilo_r <= '0;
        end else if (!stall[3]) begin
            bus_r  <= ex_to_mem_bus;
            hilo_r <= ex_to_mem1;
        end
    end

    assign pc        = bus_r[76:45];
    assign load_op   = bus_r[44:40];
    assign addr_lo   = bus_r[39:38];
    assign rf_we     = bus_r[37];
    assign rf_waddr  = bus_r[36:32];
    assign ex_result = bus_r[31:0];
    assign is_load   = |load_op;

    // Read data is only buffered when the load cannot leave MEM on the cycle it arrives;
    // otherwise the buffered copy would be attributed to the next instruction.
    always_comb begin
        state_nxt     = state;
        rdata_buf_nxt = rdata_buf;
        case (state)
            IDLE: begin
                if (is_load && data_rvalid) begin
                    if (!bus_update) begin
                        rdata_buf_nxt = data_rdata;
                        state_nxt     = DONE;
                    end
                end else if (is_load) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_rvalid) begin
                    rdata_buf_nxt = data_rdata;
                    state_nxt     = bus_update ? IDLE : DONE;
                end
            end
            DONE: begin
                if (bus_update) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rdata_buf <= '0;
        end else begin
            state     <= state_nxt;
            rdata_buf <= rdata_buf_nxt;
        end
    end

    assign stallreq_mem = is_load & ~data_rvalid & (state != DONE);

    assign raw = (state == DONE) ? rdata_buf : data_rdata;

    // load_op is one-hot {lb, lbu, lh, lhu, lw}; EX guarantees natural alignment.
    always_comb begin
        byte_v = 8'h00;
        case (addr_lo)
            2'd0:    byte_v = raw[7:0];
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = addr_lo[1] ? raw[31:16] : raw[15:0];

        load_data = raw;
        if (load_op[4]) begin
            load_data = {{24{byte_v[7]}}, byte_v};
        end else if (load_op[3]) begin
            load_data = {24'h000000, byte_v};
        end else if (load_op[2]) begin
            load_data = {{16{half_v[15]}}, half_v};
        end else if (load_op[1]) begin
            load_data = {16'h0000, half_v};
        end
    end

    assign rf_wdata = is_load ? load_data : ex_result;

    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
    assign mem_to_wb1    = hilo_r;
    assign mem_to_id_2   = hilo_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [76:0] ex_to_mem_bus;
    logic [65:0] ex_to_mem1;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic [69:0] mem_to_wb_bus;
    logic [65:0] mem_to_wb1;
    logic [37:0] mem_to_id_bus;
    logic [65:0] mem_to_id_2;
    logic        stallreq_mem;

    int checks = 0;
    int errors = 0;
    logic run_cmp = 1'b0;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_to_mem_bus (ex_to_mem_bus),
        .ex_to_mem1    (ex_to_mem1),
        .data_rdata    (data_rdata),
        .data_rvalid   (data_rvalid),
        .mem_to_wb_bus (mem_to_wb_bus),
        .mem_to_wb1    (mem_to_wb1),
        .mem_to_id_bus (mem_to_id_bus),
        .mem_to_id_2   (mem_to_id_2),
        .stallreq_mem  (stallreq_mem)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [76:0] mk_bus(input logic [31:0] pc, input logic [4:0] op,
                                           input logic [1:0] alo, input logic we,
                                           input logic [4:0] wa, input logic [31:0] res);
        return {pc, op, alo, we, wa, res};
    endfunction

    // Load extraction from the ISA rules: shift the addressed byte/half down, then extend.
    function automatic logic [31:0] extract(input logic [4:0] op, input logic [1:0] alo,
                                            input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * alo);
        case (op)
            5'b10000: return {{24{sh[7]}}, sh[7:0]};
            5'b01000: return {24'h0, sh[7:0]};
            5'b00100: return {{16{sh[15]}}, sh[15:0]};
            5'b00010: return {16'h0, sh[15:0]};
            default:  return word;
        endcase
    endfunction

    // Model: the instruction held in MEM, plus whether its load data has already arrived.
    logic [76:0] m_bus  = '0;
    logic [65:0] m_hilo = '0;
    logic        m_got  = 1'b0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_bus  <= '0;
            m_hilo <= '0;
            m_got  <= 1'b0;
            m_data <= '0;
        end else if (!stall[3] || !stall[4]) begin
            m_bus  <= stall[3] ? 77'd0 : ex_to_mem_bus;
            m_hilo <= stall[3] ? 66'd0 : ex_to_mem1;
            m_got  <= 1'b0;
        end else if ((|m_bus[44:40]) && !m_got && data_rvalid) begin
            m_got  <= 1'b1;
            m_data <= data_rdata;
        end
    end

    always @(negedge clk) begin
        logic        is_ld;
        logic [31:0] wd;
        if (run_cmp) begin
            is_ld = |m_bus[44:40];
            wd = is_ld ? extract(m_bus[44:40], m_bus[39:38], m_got ? m_data : data_rdata)
                       : m_bus[31:0];
            check_val("m_stallreq", stallreq_mem, is_ld && !m_got && !data_rvalid);
            check_val("m_wb_hdr", mem_to_wb_bus[69:32], {m_bus[76:45], m_bus[37], m_bus[36:32]});
            check_val("m_wb1", mem_to_wb1, m_hilo);
            check_val("m_id2", mem_to_id_2, m_hilo);
            if (!is_ld || m_got || data_rvalid) begin
                check_val("m_wb_wdata", mem_to_wb_bus[31:0], wd);
                check_val("m_id_bus", mem_to_id_bus, {m_bus[37], m_bus[36:32], wd});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  t_op  [6] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b10000, 5'b00001};
    logic [1:0]  t_alo [6] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0};
    logic [31:0] t_rd  [6] = '{32'h12345687, 32'hF1000000, 32'h00007FFF,
                               32'hBEEF0000, 32'h00007F00, 32'h0BADF00D};
    logic [31:0] t_exp [6] = '{32'hFFFFFF87, 32'h000000F1, 32'h00007FFF,
                               32'h0000BEEF, 32'h0000007F, 32'h0BADF00D};

    initial begin
        rst = 1'b0;
        stall = '0;
        ex_to_mem_bus = '0;
        ex_to_mem1 = '0;
        data_rdata = '0;
        data_rvalid = 1'b0;
        cyc();
        run_cmp = 1'b1;
        cyc();
        @(negedge clk);
        check_val("reset_wb", mem_to_wb_bus, 70'd0);
        check_val("reset_stall", stallreq_mem, 1'b0);
        rst = 1'b1;

        // ALU result passes straight through
        ex_to_mem_bus = mk_bus(32'h100, 5'b0, 2'd0, 1'b1, 5'd3, 32'h12345678);
        ex_to_mem1 = {2'b11, 32'hAAAA0001, 32'hBBBB0002};
        cyc();
        ex_to_mem_bus = '0;
        ex_to_mem1 = '0;
        @(negedge clk);
        check_val("add_wb", mem_to_wb_bus, {32'h100, 1'b1, 5'd3, 32'h12345678});
        check_val("add_stall", stallreq_mem, 1'b0);
        check_val("add_hilo", mem_to_id_2, {2'b11, 32'hAAAA0001, 32'hBBBB0002});

        // zero-wait lb and lbu
        ex_to_mem_bus = mk_bus(32'h104, 5'b10000, 2'd2, 1'b1, 5'd4, 32'h1002);
        cyc();
        ex_to_mem_bus = '0;
        data_rvalid = 1'b1;
        data_rdata = 32'h00800000;
        @(negedge clk);
        check_val("lb_id", mem_to_id_bus, {1'b1, 5'd4, 32'hFFFFFF80});
        check_val("lb_stall", stallreq_mem, 1'b0);
        cyc();
        data_rvalid = 1'b0;
        ex_to_mem_bus = mk_bus(32'h108, 5'b01000, 2'd2, 1'b1, 5'd5, 32'h1002);
        cyc();
        ex_to_mem_bus = '0;
        data_rvalid = 1'b1;
        @(negedge clk);
        check_val("lbu_wdata", mem_to_wb_bus[31:0], 32'h00000080);
        cyc();
        data_rvalid = 1'b0;

        // lh with three wait cycles
        ex_to_mem_bus = mk_bus(32'h10C, 5'b00100, 2'd2, 1'b1, 5'd6, 32'h2002);
        cyc();
        ex_to_mem_bus = '0;
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("lh_wait_stall", stallreq_mem, 1'b1);
            cyc();
        end
        data_rvalid = 1'b1;
        data_rdata = 32'h80010000;
        @(negedge clk);
        check_val("lh_wdata", mem_to_wb_bus[31:0], 32'hFFFF8001);
        check_val("lh_stall_clr", stallreq_mem, 1'b0);
        stall = '0;
        cyc();
        data_rvalid = 1'b0;

        // lw whose data arrives while MEM is frozen by another stage
        ex_to_mem_bus = mk_bus(32'h110, 5'b00001, 2'd0, 1'b1, 5'd7, 32'h3000);
        cyc();
        ex_to_mem_bus = '0;
        stall = 6'b011111;
        @(negedge clk);
        check_val("lw_wait_stall", stallreq_mem, 1'b1);
        cyc();
        data_rvalid = 1'b1;
        data_rdata = 32'hCAFEBABE;
        @(negedge clk);
        check_val("lw_arrive", mem_to_wb_bus[31:0], 32'hCAFEBABE);
        cyc();
        data_rvalid = 1'b0;
        data_rdata = 32'hDEADDEAD;
        @(negedge clk);
        check_val("lw_done_hold1", mem_to_wb_bus[31:0], 32'hCAFEBABE);
        check_val("lw_done_stall", stallreq_mem, 1'b0);
        cyc();
        data_rvalid = 1'b1;
        data_rdata = 32'h11111111;
        @(negedge clk);
        check_val("lw_done_hold2", mem_to_wb_bus[31:0], 32'hCAFEBABE);
        stall = '0;
        data_rvalid = 1'b0;
        cyc();

        // hold versus bubble insertion
        ex_to_mem_bus = mk_bus(32'h114, 5'b0, 2'd0, 1'b1, 5'd8, 32'hAAAA5555);
        ex_to_mem1 = {2'b01, 32'h0, 32'h00000042};
        cyc();
        ex_to_mem_bus = mk_bus(32'h118, 5'b0, 2'd0, 1'b1, 5'd9, 32'h00000099);
        stall = 6'b011000;
        cyc();
        @(negedge clk);
        check_val("hold_wb", mem_to_wb_bus, {32'h114, 1'b1, 5'd8, 32'hAAAA5555});
        stall = 6'b001000;
        cyc();
        @(negedge clk);
        check_val("bubble_wb", mem_to_wb_bus, 70'd0);
        check_val("bubble_hilo", mem_to_wb1, 66'd0);
        stall = '0;
        ex_to_mem_bus = '0;
        ex_to_mem1 = '0;
        cyc();

        // reset in the middle of a wait, then a stray late rvalid
        ex_to_mem_bus = mk_bus(32'h11C, 5'b00001, 2'd0, 1'b1, 5'd10, 32'h4000);
        ex_to_mem1 = {2'b10, 32'h77, 32'h0};
        cyc();
        ex_to_mem_bus = '0;
        ex_to_mem1 = '0;
        stall = 6'b011111;
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        stall = '0;
        data_rvalid = 1'b1;
        data_rdata = 32'h55555555;
        @(negedge clk);
        check_val("rst_wb", mem_to_wb_bus, 70'd0);
        check_val("rst_id", mem_to_id_bus, 38'd0);
        check_val("rst_hilo", mem_to_wb1, 66'd0);
        check_val("rst_stall", stallreq_mem, 1'b0);
        cyc();
        data_rvalid = 1'b0;

        // zero-wait extraction table
        for (int i = 0; i < 6; i++) begin
            ex_to_mem_bus = mk_bus(32'h200 + 32'(4 * i), t_op[i], t_alo[i], 1'b1, 5'(11 + i), 32'h0);
            cyc();
            ex_to_mem_bus = '0;
            data_rvalid = 1'b1;
            data_rdata = t_rd[i];
            @(negedge clk);
            check_val("table_wdata", mem_to_wb_bus[31:0], t_exp[i]);
            cyc();
            data_rvalid = 1'b0;
        end

        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
